// File: rtl/sc_collision_game_ctrl_pkg.sv
// Shared state encoding for the collision game controller.
package sc_collision_game_ctrl_pkg;

  localparam int STATEWIDTH = 3;

  typedef enum logic [STATEWIDTH-1:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    PLAY  = 3'd2,
    GRACE = 3'd3,
    PAUSE = 3'd4,
    OVER  = 3'd5
  } stateT;

endpackage

// File: rtl/sc_collision_game_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sc_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstLow,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rstLow || clear) begin
      count <= '0;
    end else if (enable && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sc_collision_game_ctrl.sv
// Game-loop controller: sequences the obstacle datapath, samples the collision
// flag, tracks lives with a post-hit grace window and keeps a saturating score.
//
// state | meaning
// IDLE  | waiting for start, datapath stopped
// LOAD  | one-cycle reload of obstacle registers
// PLAY  | datapath running, collisions cost a life
// GRACE | datapath running, collisions ignored until grace ticks expire
// PAUSE | datapath stopped, score and lives frozen
// OVER  | no lives left, waiting for restart
module sc_collision_game_ctrl
  import sc_collision_game_ctrl_pkg::*;
#(
  parameter int LIVES       = 3,
  parameter int LIVESWIDTH  = 2,
  parameter int GRACE_TICKS = 4,
  parameter int GRACEWIDTH  = 3,
  parameter int SCOREWIDTH  = 8
) (
  input  logic                  SC_COLLISIONCTRL_CLOCK_50,
  input  logic                  SC_COLLISIONCTRL_RESET_InLow,
  input  logic                  SC_COLLISIONCTRL_start_In,
  input  logic                  SC_COLLISIONCTRL_tick_In,
  input  logic                  SC_COLLISIONCTRL_pause_In,
  input  logic                  SC_COLLISIONCTRL_collision_In,
  output logic                  SC_COLLISIONCTRL_run_Out,
  output logic                  SC_COLLISIONCTRL_reload_Out,
  output logic                  SC_COLLISIONCTRL_hit_Out,
  output logic                  SC_COLLISIONCTRL_gameover_Out,
  output logic [LIVESWIDTH-1:0] SC_COLLISIONCTRL_lives_OutBUS,
  output logic [SCOREWIDTH-1:0] SC_COLLISIONCTRL_score_OutBUS,
  output logic [STATEWIDTH-1:0] SC_COLLISIONCTRL_state_OutBUS
);

  logic clk;
  logic rstLow;
  logic start;
  logic tick;
  logic pause;
  logic collision;

  assign clk       = SC_COLLISIONCTRL_CLOCK_50;
  assign rstLow    = SC_COLLISIONCTRL_RESET_InLow;
  assign start     = SC_COLLISIONCTRL_start_In;
  assign tick      = SC_COLLISIONCTRL_tick_In;
  assign pause     = SC_COLLISIONCTRL_pause_In;
  assign collision = SC_COLLISIONCTRL_collision_In;

  stateT                 state;
  stateT                 stateNext;
  logic [LIVESWIDTH-1:0] lives;
  logic [LIVESWIDTH-1:0] livesNext;
  logic [GRACEWIDTH-1:0] grace;
  logic [GRACEWIDTH-1:0] graceNext;
  logic                  hit;
  logic                  hitNext;
  logic                  scoreClear;
  logic                  scoreInc;
  logic [SCOREWIDTH-1:0] score;

  // State register
  always_ff @(posedge clk) begin
    if (!rstLow) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic; collision outranks pause, which outranks tick
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:  if (start) stateNext = LOAD;
      LOAD:  stateNext = PLAY;
      PLAY: begin
        if (collision) begin
          stateNext = (lives > LIVESWIDTH'(1)) ? GRACE : OVER;
        end else if (pause) begin
          stateNext = PAUSE;
        end
      end
      GRACE: if (tick && (grace <= GRACEWIDTH'(1))) stateNext = PLAY;
      PAUSE: if (!pause) stateNext = PLAY;
      OVER:  if (start) stateNext = LOAD;
      default: stateNext = IDLE;
    endcase
  end

  // Counter/pulse updates decided in the current state
  always_comb begin
    livesNext  = lives;
    graceNext  = grace;
    hitNext    = 1'b0;
    scoreClear = 1'b0;
    scoreInc   = 1'b0;
    case (state)
      IDLE, OVER: begin
        if (start) begin
          livesNext  = LIVESWIDTH'(LIVES);
          graceNext  = '0;
          scoreClear = 1'b1;
        end
      end
      PLAY: begin
        if (collision) begin
          hitNext = 1'b1;
          if (lives > LIVESWIDTH'(1)) begin
            livesNext = lives - 1'b1;
            graceNext = GRACEWIDTH'(GRACE_TICKS);
          end else begin
            livesNext = '0;
          end
        end else if (!pause && tick) begin
          scoreInc = 1'b1;
        end
      end
      GRACE: begin
        if (tick) begin
          scoreInc  = 1'b1;
          graceNext = grace - 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstLow) begin
      lives <= LIVESWIDTH'(LIVES);
      grace <= '0;
      hit   <= 1'b0;
    end else begin
      lives <= livesNext;
      grace <= graceNext;
      hit   <= hitNext;
    end
  end

  sc_sat_counter #(
    .WIDTH (SCOREWIDTH)
  ) uScore (
    .clk    (clk),
    .rstLow (rstLow),
    .clear  (scoreClear),
    .enable (scoreInc),
    .count  (score)
  );

  // Moore decodes of the registered state, so these change only at clock edges
  assign SC_COLLISIONCTRL_run_Out       = (state == PLAY) || (state == GRACE);
  assign SC_COLLISIONCTRL_reload_Out    = (state == LOAD);
  assign SC_COLLISIONCTRL_gameover_Out  = (state == OVER);
  assign SC_COLLISIONCTRL_hit_Out       = hit;
  assign SC_COLLISIONCTRL_lives_OutBUS  = lives;
  assign SC_COLLISIONCTRL_score_OutBUS  = score;
  assign SC_COLLISIONCTRL_state_OutBUS  = state;

endmodule

// File: tb/tb_sc_collision_game_ctrl.sv
// Directed bench for sc_collision_game_ctrl; a second SCOREWIDTH=2 instance shares the stimulus.
module tb_sc_collision_game_ctrl;

  logic       clk = 1'b0;
  logic       rstLow;
  logic       start;
  logic       tick;
  logic       pause;
  logic       collision;
  logic       run, reload, hit, gameover;
  logic [1:0] lives;
  logic [7:0] score;
  logic [2:0] state;
  logic       run2, reload2, hit2, gameover2;
  logic [1:0] lives2;
  logic [1:0] score2;
  logic [2:0] state2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sc_collision_game_ctrl dut (
    .SC_COLLISIONCTRL_CLOCK_50     (clk),
    .SC_COLLISIONCTRL_RESET_InLow  (rstLow),
    .SC_COLLISIONCTRL_start_In     (start),
    .SC_COLLISIONCTRL_tick_In      (tick),
    .SC_COLLISIONCTRL_pause_In     (pause),
    .SC_COLLISIONCTRL_collision_In (collision),
    .SC_COLLISIONCTRL_run_Out      (run),
    .SC_COLLISIONCTRL_reload_Out   (reload),
    .SC_COLLISIONCTRL_hit_Out      (hit),
    .SC_COLLISIONCTRL_gameover_Out (gameover),
    .SC_COLLISIONCTRL_lives_OutBUS (lives),
    .SC_COLLISIONCTRL_score_OutBUS (score),
    .SC_COLLISIONCTRL_state_OutBUS (state)
  );

  sc_collision_game_ctrl #(.SCOREWIDTH(2)) dutNarrow (
    .SC_COLLISIONCTRL_CLOCK_50     (clk),
    .SC_COLLISIONCTRL_RESET_InLow  (rstLow),
    .SC_COLLISIONCTRL_start_In     (start),
    .SC_COLLISIONCTRL_tick_In      (tick),
    .SC_COLLISIONCTRL_pause_In     (pause),
    .SC_COLLISIONCTRL_collision_In (collision),
    .SC_COLLISIONCTRL_run_Out      (run2),
    .SC_COLLISIONCTRL_reload_Out   (reload2),
    .SC_COLLISIONCTRL_hit_Out      (hit2),
    .SC_COLLISIONCTRL_gameover_Out (gameover2),
    .SC_COLLISIONCTRL_lives_OutBUS (lives2),
    .SC_COLLISIONCTRL_score_OutBUS (score2),
    .SC_COLLISIONCTRL_state_OutBUS (state2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are read at the next falling edge.
  task automatic cycle(input logic s, input logic t, input logic p, input logic c);
    start = s; tick = t; pause = p; collision = c;
    @(negedge clk);
    start = 1'b0; tick = 1'b0; collision = 1'b0;
  endtask

  initial begin
    rstLow = 1'b0; start = 1'b0; tick = 1'b0; pause = 1'b0; collision = 1'b0;
    repeat (2) @(negedge clk);
    rstLow = 1'b1;
    check("rst_state", state, 0);
    check("rst_lives", lives, 3);
    check("rst_score", score, 0);
    check("rst_run", run, 0);
    check("rst_gameover", gameover, 0);

    // Start and survive 5 ticks
    cycle(1, 0, 0, 0);
    check("load_state", state, 1);
    check("load_reload", reload, 1);
    check("load_run", run, 0);
    cycle(0, 0, 0, 0);
    check("play_state", state, 2);
    check("play_reload_gone", reload, 0);
    check("play_run", run, 1);
    repeat (5) cycle(0, 1, 0, 0);
    check("score5", score, 5);
    check("lives3", lives, 3);
    check("narrow_sat", score2, 3);
    check("narrow_state", state2, 2);

    // First hit, then collisions ignored across the grace window
    cycle(0, 0, 0, 1);
    check("hit1_pulse", hit, 1);
    check("hit1_lives", lives, 2);
    check("hit1_state", state, 3);
    repeat (3) cycle(0, 1, 0, 1);
    check("hit1_pulse_once", hit, 0);
    check("grace_state", state, 3);
    check("grace_lives", lives, 2);
    cycle(0, 1, 0, 1);
    check("grace_exit", state, 2);
    check("grace_score", score, 9);
    check("grace_lives_kept", lives, 2);

    // Collision and tick together: hit wins, no score
    cycle(0, 1, 0, 1);
    check("simul_hit", hit, 1);
    check("simul_lives", lives, 1);
    check("simul_score", score, 9);
    repeat (4) cycle(0, 1, 0, 0);
    check("grace2_exit", state, 2);
    check("grace2_score", score, 13);
    check("narrow_hold", score2, 3);

    // Pause with a same-cycle tick, ticks and collisions while paused
    cycle(0, 1, 1, 0);
    check("pause_state", state, 4);
    check("pause_run", run, 0);
    check("pause_score", score, 13);
    cycle(0, 1, 1, 1);
    cycle(0, 1, 1, 0);
    check("paused_score", score, 13);
    check("paused_lives", lives, 1);
    check("paused_hit", hit, 0);
    pause = 1'b0;
    cycle(0, 0, 0, 0);
    check("unpause_state", state, 2);
    check("unpause_run", run, 1);

    // start ignored while playing
    cycle(1, 0, 0, 0);
    check("start_ignored", state, 2);
    check("start_ignored_reload", reload, 0);

    // Last life lost
    cycle(0, 1, 0, 1);
    check("over_hit", hit, 1);
    check("over_lives", lives, 0);
    check("over_state", state, 5);
    check("over_gameover", gameover, 1);
    check("over_run", run, 0);
    check("over_score", score, 13);
    cycle(0, 1, 0, 1);
    check("over_hold_score", score, 13);
    check("over_hit_once", hit, 0);

    // Restart from OVER
    cycle(1, 0, 0, 0);
    check("restart_state", state, 1);
    check("restart_lives", lives, 3);
    check("restart_score", score, 0);
    check("restart_gameover", gameover, 0);
    cycle(0, 0, 0, 0);
    repeat (2) cycle(0, 1, 0, 0);
    check("restart_score2", score, 2);

    // Reset mid-PLAY with a collision pending: aborts, no hit pulse
    rstLow = 1'b0;
    collision = 1'b1;
    @(negedge clk);
    check("midrst_state", state, 0);
    check("midrst_lives", lives, 3);
    check("midrst_score", score, 0);
    check("midrst_run", run, 0);
    check("midrst_hit", hit, 0);
    @(negedge clk);
    rstLow = 1'b1;
    collision = 1'b0;
    cycle(0, 0, 0, 0);
    check("post_rst_idle", state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
